wb_data_resize_seq: RTL and testbench

Parametrised sequential Wishbone width converter between a wide master port (MW bits) and a narrow slave port (SW bits). It splits each master access into one narrow slave access per selected SW-wide lane, in ascending address order, and assembles the read data. It sits in wb_intercon between the CPU-side bus and 8/16-bit peripherals such as UART or SPI-flash register banks. Unlike a single-lane combinational resizer, it handles multi-byte selects (half-word and word accesses), aborts on err/rty, and handles master cycle drop.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_data_resize_seq_if.sv | 33 +++
 rtl/wb_lane_pick.sv | 27 ++
 rtl/wb_data_resize_seq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_wb_data_resize_seq.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the sequential Wishbone data-width resizer.
// Contents: classic-cycle CTI/BTE constants, FSM state encoding and the
// master response code.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ACK = 2'd0,
    ERR = 2'd1,
    RTY = 2'd2
  } resp_e;

endpackage

// File: rtl/wb_data_resize_seq_if.sv
// Wishbone classic bus bundle, parameterised on address and data width.
// master modport: drives request (adr, dat_w, sel, we, cyc, stb, cti, bte),
//                 receives response (dat_r, ack, err, rty).
// slave modport:  the mirror image.
interface wb_data_resize_seq_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err, rty
  );

endinterface

// File: rtl/wb_lane_pick.sv
// Priority encoder: returns the index of the lowest set bit of a lane mask.
// Ports:
//   i_mask  - N-bit lane mask
//   o_idx   - index of the lowest set bit (0 when the mask is empty)
//   o_valid - high when any mask bit is set
module wb_lane_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_mask,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx   = IW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_data_resize_seq.sv
// Sequential Wishbone width converter, wide master (MW) to narrow slave (SW).
// Each master access is split into one classic slave access per selected
// SW-wide lane, lowest lane first; read lanes are assembled into wbm.dat_r.
// err/rty from the slave abort the remaining lanes; a master cyc drop while
// the slave bus is busy abandons the access without a master response.
// Ports:
//   wb_clk_i  - clock
//   wb_rst_ni - asynchronous active-low reset
//   wbm       - master-facing bus (MW data), this block is its slave
//   wbs       - slave-facing bus (SW data), this block is its master
module wb_data_resize_seq
  import wb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned MW = 32,
  parameter int unsigned SW = 8
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_ni,
  wb_data_resize_seq_if.slave  wbm,
  wb_data_resize_seq_if.master wbs
);

  localparam int unsigned RATIO = MW / SW;
  localparam int unsigned LB    = $clog2(RATIO);
  localparam int unsigned SB    = $clog2(SW / 8);
  localparam int unsigned SELW  = SW / 8;
  // Address bits below one master word; replaced by {lane, byte offset 0}.
  localparam logic [AW-1:0] LOW_MASK = AW'((64'd1 << (LB + SB)) - 64'd1);

  // Latched request and sequencing state
  state_e           r_state, w_state_nxt;
  logic             r_we, w_we_nxt;
  logic [AW-1:0]    r_adr, w_adr_nxt;
  logic [MW-1:0]    r_dat, w_dat_nxt;
  logic [MW/8-1:0]  r_sel, w_sel_nxt;
  logic [RATIO-1:0] r_mask, w_mask_nxt;
  logic [LB-1:0]    r_lane, w_lane_nxt;
  logic [MW-1:0]    r_acc, w_acc_nxt;

  // Registered outputs
  logic             r_cyc, w_cyc_nxt;
  logic [AW-1:0]    r_sadr, w_sadr_nxt;
  logic [SW/8-1:0]  r_ssel, w_ssel_nxt;
  logic [SW-1:0]    r_sdat, w_sdat_nxt;
  logic             r_swe, w_swe_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_err, w_err_nxt;
  logic             r_rty, w_rty_nxt;
  logic [MW-1:0]    r_mdat, w_mdat_nxt;

  logic             w_req;
  logic [RATIO-1:0] w_in_mask;
  logic [RATIO-1:0] w_mask_clr;
  logic [RATIO-1:0] w_pick_in;
  logic [LB-1:0]    w_pick_idx;
  logic             w_pick_valid;
  logic [MW-1:0]    w_acc_upd;
  logic             w_finish;
  resp_e            w_resp;
  logic             unused_w;

  function automatic logic [AW-1:0] slave_adr(input logic [AW-1:0] a, input logic [LB-1:0] l);
    return (a & ~LOW_MASK) | (AW'(l) << SB);
  endfunction

  function automatic logic [SELW-1:0] lane_sel(input logic [MW/8-1:0] s,
                                               input logic [LB-1:0]   l);
    return s[l*SELW +: SELW];
  endfunction

  function automatic logic [SW-1:0] lane_dat(input logic [MW-1:0] d, input logic [LB-1:0] l);
    return d[l*SW +: SW];
  endfunction

  // Burst signalling from the master is not forwarded; the slave side is classic only.
  assign unused_w = ^{wbm.cti, wbm.bte};

  assign w_req = wbm.cyc & wbm.stb & ~r_ack & ~r_err & ~r_rty;

  always_comb begin
    w_in_mask = '0;
    for (int k = 0; k < int'(RATIO); k++) begin
      w_in_mask[k] = |wbm.sel[k*SELW +: SELW];
    end
  end

  assign w_mask_clr = r_mask & ~(RATIO'(1) << r_lane);
  // One encoder serves both the first-lane pick in IDLE and the next-lane pick in BUS.
  assign w_pick_in  = (r_state == IDLE) ? w_in_mask : w_mask_clr;

  wb_lane_pick #(
    .N  (RATIO),
    .IW (LB)
  ) u_lane_pick (
    .i_mask  (w_pick_in),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_adr_nxt   = r_adr;
    w_dat_nxt   = r_dat;
    w_sel_nxt   = r_sel;
    w_mask_nxt  = r_mask;
    w_lane_nxt  = r_lane;
    w_acc_nxt   = r_acc;
    w_cyc_nxt   = r_cyc;
    w_sadr_nxt  = r_sadr;
    w_ssel_nxt  = r_ssel;
    w_sdat_nxt  = r_sdat;
    w_swe_nxt   = r_swe;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rty_nxt   = 1'b0;
    w_mdat_nxt  = '0;
    w_finish    = 1'b0;
    w_resp      = ACK;

    w_acc_upd = r_acc;
    if (!r_we) begin
      w_acc_upd[r_lane*SW +: SW] = wbs.dat_r;
    end

    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_we_nxt   = wbm.we;
          w_adr_nxt  = wbm.adr;
          w_dat_nxt  = wbm.dat_w;
          w_sel_nxt  = wbm.sel;
          w_mask_nxt = w_in_mask;
          w_acc_nxt  = '0;
          if (!w_pick_valid) begin
            // Nothing selected: acknowledge without touching the slave.
            w_state_nxt = DONE;
            w_ack_nxt   = 1'b1;
          end else begin
            w_state_nxt = BUS;
            w_lane_nxt  = w_pick_idx;
            w_cyc_nxt   = 1'b1;
            w_sadr_nxt  = slave_adr(wbm.adr, w_pick_idx);
            w_ssel_nxt  = lane_sel(wbm.sel, w_pick_idx);
            w_sdat_nxt  = wbm.we ? lane_dat(wbm.dat_w, w_pick_idx) : '0;
            w_swe_nxt   = wbm.we;
          end
        end
      end

      BUS: begin
        if (!wbm.cyc) begin
          // Master gave up: release the slave bus, no master response.
          w_state_nxt = IDLE;
          w_cyc_nxt   = 1'b0;
          w_sadr_nxt  = '0;
          w_ssel_nxt  = '0;
          w_sdat_nxt  = '0;
          w_swe_nxt   = 1'b0;
          w_mask_nxt  = '0;
          w_acc_nxt   = '0;
        end else if (wbs.err) begin
          w_finish = 1'b1;
          w_resp   = ERR;
        end else if (wbs.rty) begin
          w_finish = 1'b1;
          w_resp   = RTY;
        end else if (wbs.ack) begin
          w_acc_nxt  = w_acc_upd;
          w_mask_nxt = w_mask_clr;
          if (w_pick_valid) begin
            // Back-to-back: stb stays high, lane fields move on.
            w_lane_nxt = w_pick_idx;
            w_sadr_nxt = slave_adr(r_adr, w_pick_idx);
            w_ssel_nxt = lane_sel(r_sel, w_pick_idx);
            w_sdat_nxt = r_we ? lane_dat(r_dat, w_pick_idx) : '0;
          end else begin
            w_finish = 1'b1;
            w_resp   = ACK;
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
        w_acc_nxt   = '0;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_finish) begin
      w_state_nxt = DONE;
      w_cyc_nxt   = 1'b0;
      w_sadr_nxt  = '0;
      w_ssel_nxt  = '0;
      w_sdat_nxt  = '0;
      w_swe_nxt   = 1'b0;
      w_mask_nxt  = '0;
      unique case (w_resp)
        ACK: begin
          w_ack_nxt  = 1'b1;
          w_mdat_nxt = r_we ? '0 : w_acc_upd;
        end
        ERR:     w_err_nxt = 1'b1;
        RTY:     w_rty_nxt = 1'b1;
        default: w_ack_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_mask  <= '0;
      r_lane  <= '0;
      r_acc   <= '0;
      r_cyc   <= 1'b0;
      r_sadr  <= '0;
      r_ssel  <= '0;
      r_sdat  <= '0;
      r_swe   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
      r_mdat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_adr   <= w_adr_nxt;
      r_dat   <= w_dat_nxt;
      r_sel   <= w_sel_nxt;
      r_mask  <= w_mask_nxt;
      r_lane  <= w_lane_nxt;
      r_acc   <= w_acc_nxt;
      r_cyc   <= w_cyc_nxt;
      r_sadr  <= w_sadr_nxt;
      r_ssel  <= w_ssel_nxt;
      r_sdat  <= w_sdat_nxt;
      r_swe   <= w_swe_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rty   <= w_rty_nxt;
      r_mdat  <= w_mdat_nxt;
    end
  end

  assign wbm.dat_r = r_mdat;
  assign wbm.ack   = r_ack;
  assign wbm.err   = r_err;
  assign wbm.rty   = r_rty;

  assign wbs.adr   = r_sadr;
  assign wbs.dat_w = r_sdat;
  assign wbs.sel   = r_ssel;
  assign wbs.we    = r_swe;
  assign wbs.cyc   = r_cyc;
  assign wbs.stb   = r_cyc;
  assign wbs.cti   = CTI_CLASSIC;
  assign wbs.bte   = BTE_LINEAR;

endmodule

// File: tb/tb_wb_data_resize_seq.sv
// Scoreboard bench for wb_data_resize_seq: a 32->8 and a 32->16 instance,
// each with a zero-wait slave model. Expected slave beats and master
// responses are queued by the stimulus and checked by negedge monitors.
module tb_wb_data_resize_seq;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic [2:0]  kind; // {rty, err, ack}
    logic [31:0] dat;
  } resp_t;

  localparam logic [2:0] K_ACK = 3'b001;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_RTY = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  beat_t q8[$];
  beat_t q16[$];
  resp_t r8[$];
  resp_t r16[$];
  beat_t eb8, eb16;
  resp_t er8, er16;

  int unsigned bcnt8 = 0;
  int unsigned err_at8 = 32'hFFFF_FFFF;
  int unsigned rty_at8 = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  wb_data_resize_seq_if #(.AW(32), .DW(32)) m8();
  wb_data_resize_seq_if #(.AW(32), .DW(8))  s8();
  wb_data_resize_seq_if #(.AW(32), .DW(32)) m16();
  wb_data_resize_seq_if #(.AW(32), .DW(16)) s16();

  wb_data_resize_seq #(.AW(32), .MW(32), .SW(8)) u_dut8 (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbm       (m8),
    .wbs       (s8)
  );

  wb_data_resize_seq #(.AW(32), .MW(32), .SW(16)) u_dut16 (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbm       (m16),
    .wbs       (s16)
  );

  function automatic logic [7:0] rd8(input logic [31:0] a);
    case (a[1:0])
      2'd0:    return 8'h78;
      2'd1:    return 8'h56;
      2'd2:    return 8'h34;
      default: return 8'h12;
    endcase
  endfunction

  // Zero-wait slave models; dut8 slave can inject err/rty on a chosen beat.
  assign s8.dat_r  = rd8(s8.adr);
  assign s8.err    = s8.cyc & s8.stb & (bcnt8 == err_at8);
  assign s8.rty    = s8.cyc & s8.stb & ~s8.err & (bcnt8 == rty_at8);
  assign s8.ack    = s8.cyc & s8.stb & ~s8.err & ~s8.rty;
  assign s16.dat_r = s16.adr[1] ? 16'hBEEF : 16'h1234;
  assign s16.ack   = s16.cyc & s16.stb;
  assign s16.err   = 1'b0;
  assign s16.rty   = 1'b0;

  always @(posedge clk) begin
    if (s8.cyc && s8.stb && (s8.ack || s8.err || s8.rty)) bcnt8 <= bcnt8 + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input bit w16, input logic [31:0] a, input logic [3:0] s,
                          input logic w, input logic [31:0] d);
    if (w16) q16.push_back(beat_t'{a, s, w, d});
    else     q8.push_back(beat_t'{a, s, w, d});
  endtask

  task automatic exp_resp(input bit w16, input logic [2:0] k, input logic [31:0] d);
    if (w16) r16.push_back(resp_t'{k, d});
    else     r8.push_back(resp_t'{k, d});
  endtask

  task automatic drive(input bit w16, input logic [31:0] a, input logic we,
                       input logic [3:0] sel, input logic [31:0] d, input logic req);
    if (w16) begin
      m16.adr = a; m16.we = we; m16.sel = sel; m16.dat_w = d; m16.cyc = req; m16.stb = req;
    end else begin
      m8.adr = a; m8.we = we; m8.sel = sel; m8.dat_w = d; m8.cyc = req; m8.stb = req;
    end
  endtask

  // Issue one access at posedge+1, wait for the response, check inclusive cycle count.
  task automatic access(input bit w16, input logic [31:0] a, input logic we,
                        input logic [3:0] sel, input logic [31:0] d, input int exp_cyc,
                        input string name);
    int n;
    bit done;
    drive(w16, a, we, sel, d, 1'b1);
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      done = w16 ? (m16.ack | m16.err | m16.rty) : (m8.ack | m8.err | m8.rty);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no response after %0d cycles, required within %0d", name, n,
               exp_cyc);
    end else begin
      chk({name, "_cycles"}, 64'(n + 1), 64'(exp_cyc));
    end
    drive(w16, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // Monitors: sample away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s8.cyc && s8.stb && (s8.ack || s8.err || s8.rty)) begin
        if (q8.size() == 0) begin
          total++;
          bad++;
          $display("FAIL s8_beat: unexpected strobe adr %h, required none", s8.adr);
        end else begin
          eb8 = q8.pop_front();
          chk("s8_adr", 64'(s8.adr), 64'(eb8.adr));
          chk("s8_sel", 64'(s8.sel), 64'(eb8.sel));
          chk("s8_we", 64'(s8.we), 64'(eb8.we));
          chk("s8_dat", 64'(s8.dat_w), 64'(eb8.dat));
          chk("s8_cti_bte", 64'({s8.bte, s8.cti}), 64'(0));
        end
      end
      if (m8.ack || m8.err || m8.rty) begin
        if (r8.size() == 0) begin
          total++;
          bad++;
          $display("FAIL m8_resp: unexpected response %b, required none",
                   {m8.rty, m8.err, m8.ack});
        end else begin
          er8 = r8.pop_front();
          chk("m8_kind", 64'({m8.rty, m8.err, m8.ack}), 64'(er8.kind));
          chk("m8_dat", 64'(m8.dat_r), 64'(er8.dat));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (s16.cyc && s16.stb && s16.ack) begin
        if (q16.size() == 0) begin
          total++;
          bad++;
          $display("FAIL s16_beat: unexpected strobe adr %h, required none", s16.adr);
        end else begin
          eb16 = q16.pop_front();
          chk("s16_adr", 64'(s16.adr), 64'(eb16.adr));
          chk("s16_sel", 64'(s16.sel), 64'(eb16.sel));
          chk("s16_we", 64'(s16.we), 64'(eb16.we));
          chk("s16_dat", 64'(s16.dat_w), 64'(eb16.dat));
        end
      end
      if (m16.ack || m16.err || m16.rty) begin
        if (r16.size() == 0) begin
          total++;
          bad++;
          $display("FAIL m16_resp: unexpected response %b, required none",
                   {m16.rty, m16.err, m16.ack});
        end else begin
          er16 = r16.pop_front();
          chk("m16_kind", 64'({m16.rty, m16.err, m16.ack}), 64'(er16.kind));
          chk("m16_dat", 64'(m16.dat_r), 64'(er16.dat));
        end
      end
    end
  end

  task automatic chk_quiet(input string name);
    chk({name, "_m8"}, 64'({m8.ack, m8.err, m8.rty, m8.dat_r}), 64'(0));
    chk({name, "_s8"}, 64'({s8.cyc, s8.stb, s8.we, s8.sel, s8.dat_w, s8.adr}), 64'(0));
    chk({name, "_m16"}, 64'({m16.ack, m16.err, m16.rty, m16.dat_r}), 64'(0));
    chk({name, "_s16"}, 64'({s16.cyc, s16.stb, s16.we, s16.sel, s16.dat_w, s16.adr}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    m8.cti = 3'b010; m8.bte = 2'b01;
    m16.cti = 3'b000; m16.bte = 2'b00;

    #1 rst_n = 1'b0;
    #2 chk_quiet("reset");
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-word read through 8-bit slave; low master address bits ignored.
    exp_beat(1'b0, 32'h1000_0000, 4'h1, 1'b0, 32'h0);
    exp_beat(1'b0, 32'h1000_0001, 4'h1, 1'b0, 32'h0);
    exp_beat(1'b0, 32'h1000_0002, 4'h1, 1'b0, 32'h0);
    exp_beat(1'b0, 32'h1000_0003, 4'h1, 1'b0, 32'h0);
    exp_resp(1'b0, K_ACK, 32'h1234_5678);
    access(1'b0, 32'h1000_0002, 1'b0, 4'b1111, 32'h0, 6, "rd_word8");

    // Middle half-word write.
    exp_beat(1'b0, 32'h2000_0011, 4'h1, 1'b1, 32'h0000_00CC);
    exp_beat(1'b0, 32'h2000_0012, 4'h1, 1'b1, 32'h0000_00BB);
    exp_resp(1'b0, K_ACK, 32'h0);
    access(1'b0, 32'h2000_0010, 1'b1, 4'b0110, 32'hAABB_CCDD, 4, "wr_mid8");

    // Sparse read: unselected lanes come back zero.
    exp_beat(1'b0, 32'h1000_0008, 4'h1, 1'b0, 32'h0);
    exp_beat(1'b0, 32'h1000_000A, 4'h1, 1'b0, 32'h0);
    exp_resp(1'b0, K_ACK, 32'h0034_0078);
    access(1'b0, 32'h1000_0008, 1'b0, 4'b0101, 32'h0, 4, "rd_sparse8");

    // 16-bit slave: upper half read, lower byte write.
    exp_beat(1'b1, 32'h3000_0006, 4'h3, 1'b0, 32'h0);
    exp_resp(1'b1, K_ACK, 32'hBEEF_0000);
    access(1'b1, 32'h3000_0004, 1'b0, 4'b1100, 32'h0, 3, "rd_hi16");

    exp_beat(1'b1, 32'h3000_0008, 4'h1, 1'b1, 32'h0000_3344);
    exp_resp(1'b1, K_ACK, 32'h0);
    access(1'b1, 32'h3000_0008, 1'b1, 4'b0001, 32'h1122_3344, 3, "wr_lo16");

    // Error on the second beat ends the access.
    err_at8 = bcnt8 + 1;
    exp_beat(1'b0, 32'h4000_0000, 4'h1, 1'b0, 32'h0);
    exp_beat(1'b0, 32'h4000_0001, 4'h1, 1'b0, 32'h0);
    exp_resp(1'b0, K_ERR, 32'h0);
    access(1'b0, 32'h4000_0000, 1'b0, 4'b1111, 32'h0, 4, "rd_err8");
    err_at8 = 32'hFFFF_FFFF;

    // Retry on the only beat.
    rty_at8 = bcnt8;
    exp_beat(1'b0, 32'h4000_0013, 4'h1, 1'b0, 32'h0);
    exp_resp(1'b0, K_RTY, 32'h0);
    access(1'b0, 32'h4000_0010, 1'b0, 4'b1000, 32'h0, 3, "rd_rty8");
    rty_at8 = 32'hFFFF_FFFF;

    // Empty select: ack with no slave access.
    exp_resp(1'b0, K_ACK, 32'h0);
    access(1'b0, 32'h4000_0020, 1'b0, 4'b0000, 32'h0, 2, "rd_nosel8");

    // Master drops cyc during the second beat.
    exp_beat(1'b0, 32'h5000_0000, 4'h1, 1'b0, 32'h0);
    exp_beat(1'b0, 32'h5000_0001, 4'h1, 1'b0, 32'h0);
    drive(1'b0, 32'h5000_0000, 1'b0, 4'b1111, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("abort_cyc", 64'({s8.cyc, s8.stb}), 64'(0));
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset while the slave bus is busy.
    exp_beat(1'b0, 32'h6000_0000, 4'h1, 1'b0, 32'h0);
    drive(1'b0, 32'h6000_0000, 1'b0, 4'b1111, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    exp_beat(1'b0, 32'h7000_0000, 4'h1, 1'b0, 32'h0);
    exp_beat(1'b0, 32'h7000_0001, 4'h1, 1'b0, 32'h0);
    exp_beat(1'b0, 32'h7000_0002, 4'h1, 1'b0, 32'h0);
    exp_beat(1'b0, 32'h7000_0003, 4'h1, 1'b0, 32'h0);
    exp_resp(1'b0, K_ACK, 32'h1234_5678);
    access(1'b0, 32'h7000_0000, 1'b0, 4'b1111, 32'h0, 6, "rd_after_rst8");

    repeat (2) @(posedge clk);
    #1;
    chk("q8_left", 64'(q8.size()), 64'(0));
    chk("q16_left", 64'(q16.size()), 64'(0));
    chk("r8_left", 64'(r8.size()), 64'(0));
    chk("r16_left", 64'(r16.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
